// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int OFFSET_BITS     = 4;
  localparam int BLOCK_ADDR_BITS = 32 - OFFSET_BITS;
  localparam int DEFAULT_SETS    = 8;
  localparam int INDEX_BITS      = $clog2(DEFAULT_SETS);
  localparam int TAG_BITS        = BLOCK_ADDR_BITS - INDEX_BITS;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    REFILL
  } state_e;

endpackage

// File: rtl/dcache_wb_store_merge.sv
// Merges a byte/halfword/word store into a 128-bit cache line.
module dcache_store_merge
  import dcache_pkg::*;
(
  input  logic [127:0] line,
  input  logic [1:0]   word_sel,
  input  logic [1:0]   byte_sel,
  input  logic [2:0]   funct3,
  input  logic [31:0]  wdata,
  output logic [127:0] merged
);

  logic [31:0] old_word;
  logic [31:0] new_word;

  always_comb begin
    old_word = line[{word_sel, 5'b0} +: 32];
    new_word = old_word;
    case (funct3)
      F3_SB:   new_word[{byte_sel, 3'b0} +: 8] = wdata[7:0];
      F3_SH:   new_word[{byte_sel[1], 4'b0} +: 16] = wdata[15:0];
      default: new_word = wdata;
    endcase
    merged = line;
    merged[{word_sel, 5'b0} +: 32] = new_word;
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add the access_count / miss_count outputs.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int SETS        = DEFAULT_SETS,
  parameter int BLOCK_WORDS = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  input  logic [2:0]   funct3,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  access_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = BLOCK_ADDR_BITS - IDX_W;

  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word_sel;

  assign index    = address[OFFSET_BITS +: IDX_W];
  assign tag      = address[31 -: TAG_W];
  assign word_sel = address[3:2];

  logic [127:0]     data_q [SETS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  state_e           state_q, state_d;
  logic [127:0]     fill_q, fill_d;

  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [27:0]      mem_address_q, mem_address_d;
  logic [127:0]     mem_writedata_q, mem_writedata_d;

  logic [127:0]     line;
  logic [127:0]     merged;
  logic             line_we;
  logic [127:0]     line_wdata;
  logic [TAG_W-1:0] line_wtag;
  logic             req;
  logic             hit;

  assign line     = data_q[index];
  assign req      = read | write;
  assign hit      = valid_q[index] && (tag_q[index] == tag);
  assign busywait = req && !(state_q == IDLE && hit);
  assign readdata = line[{word_sel, 5'b0} +: 32];

  dcache_store_merge u_merge (
    .line     (line),
    .word_sel (word_sel),
    .byte_sel (address[1:0]),
    .funct3   (funct3),
    .wdata    (writedata),
    .merged   (merged)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    fill_d     = fill_q;
    line_we    = 1'b0;
    line_wdata = merged;
    line_wtag  = tag;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (write) begin
              line_we        = 1'b1;
              dirty_d[index] = 1'b1;
            end
          end else if (valid_q[index] && dirty_q[index]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WRITEBACK: if (!mem_busywait) state_d = FETCH;
      FETCH: begin
        if (!mem_busywait) begin
          fill_d  = mem_readdata;
          state_d = REFILL;
        end
      end
      REFILL: begin
        line_we        = 1'b1;
        line_wdata     = fill_q;
        valid_d[index] = 1'b1;
        dirty_d[index] = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are registered from the upcoming state.
  always_comb begin
    mem_read_d      = (state_d == FETCH);
    mem_write_d     = (state_d == WRITEBACK);
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    if (state_d == FETCH) begin
      mem_address_d = address[31:4];
    end else if (state_d == WRITEBACK) begin
      mem_address_d   = {tag_q[index], index};
      mem_writedata_d = line;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // NOTE: data/tag arrays and the staging block carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
    if (line_we) begin
      data_q[index] <= line_wdata;
      tag_q[index]  <= line_wtag;
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] access_count_q, access_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    access_count_d = access_count_q + ((req && !busywait) ? 32'd1 : 32'd0);
    miss_count_d   = miss_count_q + ((state_q == IDLE && state_d != IDLE) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      access_count_q <= '0;
      miss_count_q   <= '0;
    end else begin
      access_count_q <= access_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign access_count = access_count_q;
  assign miss_count   = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb with a fixed-latency block memory.
module tb_dcache_wb;

  localparam int LAT = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         read, write;
  logic [31:0]  address, writedata;
  logic [2:0]   funct3;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
  logic         mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [31:0]  access_count, miss_count;
`endif

  dcache_wb dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .funct3        (funct3),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .access_count  (access_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: each transfer completes on its LAT-th busy cycle.
  int mem_cnt = 0;
  assign mem_busywait = (mem_cnt != LAT - 1);

  always @(posedge CLK) begin
    if ((mem_read || mem_write) && mem_busywait) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  function automatic logic [127:0] blk(input logic [27:0] a);
    if (a == 28'h4) return 128'h44444444_33333333_22222222_11111111;
    return {4{4'h0, a}};
  endfunction

  assign mem_readdata = blk(mem_address);

  int           rd_cycles = 0;
  int           wr_cycles = 0;
  logic [27:0]  last_rd_addr = '0;
  logic [27:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  always @(negedge CLK) begin
    if (mem_read) begin
      rd_cycles++;
      last_rd_addr = mem_address;
    end
    if (mem_write) begin
      wr_cycles++;
      last_wr_addr = mem_address;
      last_wr_data = mem_writedata;
    end
  end

  task automatic req(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] f);
    @(posedge CLK);
    #1;
    read      = r;
    write     = w;
    address   = a;
    writedata = wd;
    funct3    = f;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    @(negedge CLK);
    while (busywait && cycles < 50) begin
      cycles++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, rd0, wr0, tr0;
    RESET = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; funct3 = 3'b010;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_writedata", mem_writedata, 0);
    check("rst_busywait", busywait, 0);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Clean miss on 0x40
    rd0 = rd_cycles;
    req(1, 0, 32'h40, 0, 3'b010);
    wait_done(n);
    check("miss_stall", n, 7);
    check("miss_data", readdata, 32'h11111111);
    check("miss_rd_cycles", rd_cycles - rd0, LAT);
    check("miss_rd_addr", last_rd_addr, 28'h4);
`ifdef DCACHE_STATS_EN
    check("miss_count", miss_count, 1);
`endif

    req(1, 0, 32'h48, 0, 3'b010);
    @(negedge CLK);
    check("hit_busy", busywait, 0);
    check("hit_data", readdata, 32'h33333333);

    // Store merges, all hits
    tr0 = rd_cycles + wr_cycles;
    req(0, 1, 32'h41, 32'hFFFFFFAB, 3'b000);
    @(negedge CLK);
    check("sb_busy", busywait, 0);
    req(0, 1, 32'h46, 32'h1234BEEF, 3'b001);
    @(negedge CLK);
    check("sh_busy", busywait, 0);
    req(0, 1, 32'h4D, 32'hCAFEF00D, 3'b111);
    @(negedge CLK);
    check("sw_dflt_busy", busywait, 0);
    req(1, 0, 32'h44, 0, 3'b010);
    @(negedge CLK);
    check("sh_data", readdata, 32'hBEEF2222);
    req(1, 0, 32'h40, 0, 3'b010);
    @(negedge CLK);
    check("sb_data", readdata, 32'h1111AB11);
    req(1, 0, 32'h4C, 0, 3'b010);
    @(negedge CLK);
    check("sw_dflt_data", readdata, 32'hCAFEF00D);
    check("no_traffic", rd_cycles + wr_cycles, tr0);

    // Dirty miss on 0xC0 evicts the merged line
    rd0 = rd_cycles;
    wr0 = wr_cycles;
    req(1, 0, 32'hC0, 0, 3'b010);
    wait_done(n);
    check("dirty_stall", n, 12);
    check("wb_cycles", wr_cycles - wr0, LAT);
    check("wb_addr", last_wr_addr, 28'h4);
    check("wb_data", last_wr_data, 128'hCAFEF00D_33333333_BEEF2222_1111AB11);
    check("fetch_cycles", rd_cycles - rd0, LAT);
    check("fetch_addr", last_rd_addr, 28'hC);
    check("dirty_data", readdata, 32'h0000000C);

    // Reset during a fetch
    req(1, 0, 32'h40, 0, 3'b010);
    @(negedge CLK);
    @(negedge CLK);
    check("fetch_active", mem_read, 1);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    read  = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_abort_read", mem_read, 0);
    check("rst_abort_addr", mem_address, 0);
    RESET   = 1'b0;
    read    = 1'b1;
    address = 32'hC0;
    wait_done(n);
    check("post_rst_stall", n, 7);
    check("post_rst_data", readdata, 32'h0000000C);

    // Simultaneous read+write treated as a store
    req(1, 0, 32'h40, 0, 3'b010);
    wait_done(n);
    check("refetch_stall", n, 7);
    req(1, 1, 32'h40, 32'hDEADBEEF, 3'b010);
    @(negedge CLK);
    check("rw_busy", busywait, 0);
    req(1, 0, 32'h40, 0, 3'b010);
    @(negedge CLK);
    check("rw_data", readdata, 32'hDEADBEEF);
    wr0 = wr_cycles;
    req(1, 0, 32'hC0, 0, 3'b010);
    wait_done(n);
    check("rw_dirty_stall", n, 12);
    check("rw_wb_cycles", wr_cycles - wr0, LAT);
    check("rw_wb_data", last_wr_data, 128'h44444444_33333333_22222222_DEADBEEF);

    req(0, 0, 32'h0, 0, 3'b010);
    @(negedge CLK);
    check("idle_busy", busywait, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
